// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for the RV32I core. Owns the PC register and the
//   fetch FSM (FETCH -> WAIT -> HOLD). It issues one instruction-memory read at
//   a time and holds the fetched word for decode until execute retires it.
//   On retire it loads the next PC from the redirect inputs.
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : a misaligned next PC at retire loads pc, enters HALT and sets
//                 the sticky fetch_fault; only reset_n leaves HALT.
//     undefined : next PC bits [1:0] are forced to 0, fetch_fault is tied to 0.
//
// Parameters
//   XLEN       datapath width (only 32 is supported)
//   RESET_PC   PC loaded on reset
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr    one-cycle read strobe and word address (= pc)
//   imem_rvalid/rdata     read response pulse and instruction word
//   instr_valid/ready     held-instruction handshake with execute
//   instr, pc, pc_plus4   held instruction, its PC and PC + 4
//   Branch, Jump, Jalr,   redirect controls, sampled only at retire
//   Zero, PCTarget,
//   ALUResult
//   fetch_fault           sticky misaligned-target halt flag
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   input  logic            Branch,
   input  logic            Jump,
   input  logic            Jalr,
   input  logic            Zero,
   input  logic [XLEN-1:0] PCTarget,
   input  logic [XLEN-1:0] ALUResult,
   output logic            fetch_fault
);

   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] next_pc_raw;
   logic [XLEN-1:0] next_pc;
   logic            req_c;
   logic            valid_c;
   logic            pc_load;
   logic            instr_load;
   logic            trap;

   assign pc_plus4 = pc_q + XLEN'(4);

   // Jalr has priority over Jump/taken branch; its target has bit 0 cleared.
   always_comb begin
      if (Jalr)
         next_pc_raw = ALUResult & ~XLEN'(1);
      else if (Jump || (Branch && Zero))
         next_pc_raw = PCTarget;
      else
         next_pc_raw = pc_plus4;
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign next_pc = next_pc_raw;
   assign trap    = (state_q == S_HOLD) && instr_ready && (next_pc_raw[1:0] != 2'b00);
`else
   assign next_pc = next_pc_raw & ~XLEN'(3);
   assign trap    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      req_c      = 1'b0;
      valid_c    = 1'b0;
      pc_load    = 1'b0;
      instr_load = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            // Any response arriving here belongs to an aborted access.
            req_c   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_load = 1'b1;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            valid_c = 1'b1;
            if (instr_ready) begin
               pc_load = 1'b1;
               state_d = trap ? state_t'(2'd3) : S_FETCH;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= S_FETCH;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP;
      end else begin
         if (pc_load)
            pc_q <= next_pc;
         if (instr_load)
            instr_q <= imem_rdata;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         fault_q <= 1'b0;
      else if (trap)
         fault_q <= 1'b1;
   end
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

   // The state register resets to FETCH, so the strobe is masked while
   // reset is held to keep imem_req low during reset.
   assign imem_req    = req_c & reset_n;
   assign imem_addr   = pc_q;
   assign instr_valid = valid_c;
   assign instr       = instr_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        Branch = 1'b0;
   logic        Jump = 1'b0;
   logic        Jalr = 1'b0;
   logic        Zero = 1'b0;
   logic [31:0] PCTarget = '0;
   logic [31:0] ALUResult = '0;
   logic        fetch_fault;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr      (instr),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .Branch     (Branch),
      .Jump       (Jump),
      .Jalr       (Jalr),
      .Zero       (Zero),
      .PCTarget   (PCTarget),
      .ALUResult  (ALUResult),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      int unsigned rdelay;
      int unsigned hdelay;
      logic        br, jp, jr, z;
      logic [31:0] tgt, alu;
      logic [31:0] exp_next;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   sb_t         sb[$];
   vec_t        vecs[9];
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] last_instr = NOP;

   function automatic vec_t mk(logic [31:0] rdata, int unsigned rdelay, int unsigned hdelay,
                               logic br, logic jp, logic jr, logic z,
                               logic [31:0] tgt, logic [31:0] alu, logic [31:0] exp_next);
      vec_t v;
      v.rdata = rdata; v.rdelay = rdelay; v.hdelay = hdelay;
      v.br = br; v.jp = jp; v.jr = jr; v.z = z;
      v.tgt = tgt; v.alu = alu; v.exp_next = exp_next;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One full fetch/decode/retire transaction starting from FETCH.
   task automatic fetch_one(input logic [31:0] exp_addr, input vec_t v, input bit stale);
      int unsigned n;
      sb_t         e;
      #1;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {31'd0, imem_req}, 32'd1);
      if (!imem_req) return;
      chk("imem_addr", imem_addr, exp_addr);
      chk("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
      chk("fault_clear", {31'd0, fetch_fault}, 32'd0);
      if (stale) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      for (int i = 0; i < int'(v.rdelay); i++) begin
         chk("wait_req_low", {31'd0, imem_req}, 32'd0);
         chk("wait_valid_low", {31'd0, instr_valid}, 32'd0);
         @(negedge clk);
      end
      chk("wait_req_low", {31'd0, imem_req}, 32'd0);
      chk("wait_instr", instr, last_instr);
      imem_rvalid = 1'b1;
      imem_rdata  = v.rdata;
      sb.push_back('{addr: exp_addr, data: v.rdata});
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_BAD0;
      chk("valid_after_rvalid", {31'd0, instr_valid}, 32'd1);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("instr", instr, e.data);
      chk("pc", pc, e.addr);
      chk("pc_plus4", pc_plus4, e.addr + 32'd4);
      last_instr = e.data;
      for (int i = 0; i < int'(v.hdelay); i++) begin
         instr_ready = 1'b0;
         if (i == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hFFFF_FFFF;
         end
         @(negedge clk);
         imem_rvalid = 1'b0;
         chk("hold_instr", instr, e.data);
         chk("hold_pc", pc, e.addr);
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_req_low", {31'd0, imem_req}, 32'd0);
      end
      instr_ready = 1'b1;
      Branch = v.br; Jump = v.jp; Jalr = v.jr; Zero = v.z;
      PCTarget = v.tgt; ALUResult = v.alu;
      @(negedge clk);
      instr_ready = 1'b0;
      Branch = 1'b0; Jump = 1'b0; Jalr = 1'b0; Zero = 1'b0;
      PCTarget = 32'h5555_5555; ALUResult = 32'hAAAA_AAAB;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_addr;
      vec_t        plain;

      plain = mk(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      //          rdata          rd hd br jp jr z  PCTarget      ALUResult     next
      vecs[0] = mk(32'h0010_0093, 0, 0, 0, 0, 0, 0, 32'h0000_0400, 32'h0,        32'h0000_0004);
      vecs[1] = mk(32'h0050_0093, 5, 4, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0008);
      vecs[2] = mk(32'h0020_8463, 0, 0, 1, 0, 0, 0, 32'h0000_0040, 32'h0,        32'h0000_000C);
      vecs[3] = mk(32'h0020_8463, 1, 1, 1, 0, 0, 1, 32'h0000_0040, 32'h0,        32'h0000_0040);
      vecs[4] = mk(32'h0000_80E7, 0, 2, 0, 1, 1, 0, 32'h0000_0080, 32'h0000_0105, 32'h0000_0104);
      vecs[5] = mk(32'h0400_006F, 2, 0, 0, 1, 0, 0, 32'h0000_0200, 32'h0,        32'h0000_0200);
      vecs[6] = mk(32'h0000_0013, 0, 0, 0, 0, 0, 1, 32'h0000_0300, 32'h0,        32'h0000_0204);
      vecs[7] = mk(32'h0000_8067, 0, 0, 0, 0, 1, 0, 32'h0000_0010, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
      vecs[8] = mk(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0000);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, NOP);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      reset_n = 1'b1;

      // Table-driven sequence; each entry's redirect picks the next address.
      exp_addr = 32'h0;
      for (int i = 0; i < 9; i++) begin
         fetch_one(exp_addr, vecs[i], 1'b0);
         exp_addr = vecs[i].exp_next;
      end

      // Reset while in WAIT, then a stale response lands in FETCH.
      #1;
      chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
      chk("pre_reset_addr", imem_addr, exp_addr);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_req", {31'd0, imem_req}, 32'd0);
      chk("abort_pc", pc, 32'h0);
      chk("abort_instr", instr, NOP);
      chk("abort_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      last_instr = NOP;
      fetch_one(32'h0, plain, 1'b1);

      // Misaligned jump target.
      fetch_one(32'h4, mk(32'h0220_006F, 0, 0, 0, 1, 0, 0, 32'h0000_0022, 32'h0, 32'h0), 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 6; i++) begin
         chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
         chk("halt_pc", pc, 32'h0000_0022);
         chk("halt_req_low", {31'd0, imem_req}, 32'd0);
         chk("halt_valid_low", {31'd0, instr_valid}, 32'd0);
         @(negedge clk);
      end
`else
      fetch_one(32'h0000_0020, plain, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
